countdown_timer_controller: RTL and testbench

//  Sequences the two-digit BCD down-counter datapath as a start/pause/load countdown timer.

---
 rtl/countdown_timer_controller_pkg.sv | 26 ++
 rtl/countdown_timer_controller_if.sv | 31 +++
 rtl/countdown_timer_controller_tick_enable.sv | 36 +++
 rtl/countdown_timer_controller.sv | 151 +++++++++++++++
 tb/tb_countdown_timer_controller.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_controller_pkg.sv
// Shared state codes, constants and preset sanitising helper for the countdown timer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t           IDLE/RUN/PAUSE/DONE codes (2'd0..2'd3)
//   DEFAULT_TICK_DIV  CLK_50M cycles per count tick at 10 Hz from 50 MHz
//   BCD_MAX           largest legal BCD digit
//   bcd_clamp()       maps any nibble above 9 to 9
package countdown_timer_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int          DEFAULT_TICK_DIV = 5000000;
    localparam logic [3:0]  BCD_MAX          = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/countdown_timer_controller_if.sv
// Button/preset/LED bundle between the board front-end and the countdown timer.
// Latency: n/a (wires only).
// Backpressure: none; buttons are single-cycle pulses, outputs are levels.
//
// Signals:
//   start_pulse, load_pulse        one-cycle button pulses (debounced upstream)
//   preset_tens, preset_units      BCD preset digits
//   LED                            {tens, units} BCD count
//   running, done                  status levels
// Modports: master = button/board side, slave = timer controller.
interface countdown_timer_controller_if;

    logic       start_pulse;
    logic       load_pulse;
    logic [3:0] preset_tens;
    logic [3:0] preset_units;
    logic [7:0] LED;
    logic       running;
    logic       done;

    modport master (
        output start_pulse, load_pulse, preset_tens, preset_units,
        input  LED, running, done
    );

    modport slave (
        input  start_pulse, load_pulse, preset_tens, preset_units,
        output LED, running, done
    );

endinterface

// File: rtl/countdown_timer_controller_tick_enable.sv
// Tick divider: one-cycle tick every TICK_DIV cycles while enabled.
// Latency: first tick TICK_DIV cycles after en rises; tick is combinational from the count.
// Backpressure: none; dropping en clears the count so re-enabling waits a full period.
//
// Ports:
//   CLK_50M  clock, rising edge
//   RST      synchronous active-high reset
//   en       count enable (high only while the timer is running)
//   tick     high for one cycle when the count is at TICK_DIV-1
module module_tick_enable #(
    parameter int TICK_DIV = 5000000,
    parameter int TICK_W   = 23
) (
    input  logic CLK_50M,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge CLK_50M) begin
        if (RST || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_controller.sv
// Start/pause/load two-digit BCD countdown timer driving LED = {tens, units}.
// Latency: every LED/state/status update visible 1 cycle after the causing edge; first decrement TICK_DIV cycles after entering RUN.
// Backpressure: none; load_pulse beats start_pulse, and in RUN load beats a coincident tick.
//
// Ports:
//   CLK_50M  clock, rising edge
//   RST      synchronous active-high reset
//   bus      slave modport: start_pulse, load_pulse, preset_tens, preset_units in;
//            LED, running, done out
// Build option: COUNTDOWN_AUTO_RELOAD_EN - reaching 00 reloads the preset and keeps running,
//               with done pulsing for one cycle; DONE is then only reached with a 00 preset.
module countdown_timer_controller
    import countdown_timer_controller_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int TICK_W   = 23
) (
    input  logic                          CLK_50M,
    input  logic                          RST,
    countdown_timer_controller_if.slave   bus
);

    state_t     state;
    logic [3:0] tens;
    logic [3:0] units;
    logic       running_q;
    logic       done_q;
    logic       tick;

    logic [7:0] preset_s;
    logic [3:0] dec_tens;
    logic [3:0] dec_units;
    logic       dec_zero;

    module_tick_enable #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick (
        .CLK_50M (CLK_50M),
        .RST     (RST),
        .en      (state == S_RUN),
        .tick    (tick)
    );

    assign preset_s = {bcd_clamp(bus.preset_tens), bcd_clamp(bus.preset_units)};

    // BCD borrow. RUN is never entered at 00, so tens is non-zero whenever units is 0.
    always_comb begin
        dec_tens  = tens;
        dec_units = units - 4'd1;
        if (units == 4'd0) begin
            dec_units = BCD_MAX;
            dec_tens  = tens - 4'd1;
        end
        dec_zero = (dec_tens == 4'd0) && (dec_units == 4'd0);
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state     <= S_IDLE;
            tens      <= 4'd0;
            units     <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load_pulse) begin
                        {tens, units} <= preset_s;
                    end else if (bus.start_pulse) begin
                        if ({tens, units} != 8'h00) begin
                            state     <= S_RUN;
                            running_q <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.load_pulse) begin
                        {tens, units} <= preset_s;
                        state         <= S_IDLE;
                        running_q     <= 1'b0;
                    end else if (tick && dec_zero) begin
                        // Reaching 00 takes precedence over a coincident start (no pause at 00).
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (preset_s == 8'h00) begin
                            {tens, units} <= 8'h00;
                            state         <= S_DONE;
                            running_q     <= 1'b0;
                        end else begin
                            {tens, units} <= preset_s;
                            if (bus.start_pulse) begin
                                state     <= S_PAUSE;
                                running_q <= 1'b0;
                            end
                        end
                        done_q <= 1'b1;
`else
                        {tens, units} <= 8'h00;
                        state         <= S_DONE;
                        running_q     <= 1'b0;
                        done_q        <= 1'b1;
`endif
                    end else begin
                        if (tick) begin
                            tens  <= dec_tens;
                            units <= dec_units;
                        end
                        if (bus.start_pulse) begin
                            state     <= S_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                end

                S_PAUSE: begin
                    if (bus.load_pulse) begin
                        {tens, units} <= preset_s;
                        state         <= S_IDLE;
                    end else if (bus.start_pulse) begin
                        state     <= S_RUN;
                        running_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.load_pulse) begin
                        {tens, units} <= preset_s;
                        state         <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LED     = {tens, units};
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer_controller.sv
// Directed bench for countdown_timer_controller with TICK_DIV=4.
// Latency: n/a. Backpressure: n/a.
module tb_countdown_timer_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    countdown_timer_controller_if bus();

    countdown_timer_controller #(
        .TICK_DIV (4),
        .TICK_W   (3)
    ) dut (
        .CLK_50M (clk),
        .RST     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] t, input logic [3:0] u);
        bus.preset_tens  = t;
        bus.preset_units = u;
        bus.load_pulse   = 1'b1;
        step(1);
        bus.load_pulse   = 1'b0;
    endtask

    task automatic start();
        bus.start_pulse = 1'b1;
        step(1);
        bus.start_pulse = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        checks   = 0;
        failures = 0;
        bus.start_pulse  = 1'b0;
        bus.load_pulse   = 1'b0;
        bus.preset_tens  = 4'd0;
        bus.preset_units = 4'd0;

        // Reset state
        rst = 1'b1;
        step(2);
        check("reset_led", bus.LED, 8'h00);
        check("reset_running", {7'd0, bus.running}, 8'h00);
        check("reset_done", {7'd0, bus.done}, 8'h00);
        rst = 1'b0;

        // 1: 23 -> 19, four cycles per step
        load(4'd2, 4'd3);
        check("t1_load", bus.LED, 8'h23);
        start();
        check("t1_running", {7'd0, bus.running}, 8'h01);
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h21; exp_seq[2] = 8'h20; exp_seq[3] = 8'h19;
        for (int i = 0; i < 4; i++) begin
            step(3);
            check("t1_hold", bus.LED, (i == 0) ? 8'h23 : exp_seq[i-1]);
            step(1);
            check("t1_step", bus.LED, exp_seq[i]);
        end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // 2: 02 -> 01 -> 00 then DONE; start ignored
        load(4'd0, 4'd2);
        check("t2_load_in_run", bus.LED, 8'h02);
        check("t2_idle", {7'd0, bus.running}, 8'h00);
        start();
        step(4);
        check("t2_01", bus.LED, 8'h01);
        step(4);
        check("t2_00", bus.LED, 8'h00);
        check("t2_done", {7'd0, bus.done}, 8'h01);
        check("t2_not_running", {7'd0, bus.running}, 8'h00);
        start();
        check("t2_start_ignored_led", bus.LED, 8'h00);
        check("t2_start_ignored_done", {7'd0, bus.done}, 8'h01);
        step(3);
        check("t2_done_held", {7'd0, bus.done}, 8'h01);
`else
        // Auto-reload: 02, 01, 02 with a one-cycle done pulse at the wrap
        load(4'd0, 4'd2);
        start();
        step(4);
        check("ar_01", bus.LED, 8'h01);
        step(3);
        check("ar_pre_wrap_done", {7'd0, bus.done}, 8'h00);
        step(1);
        check("ar_reload", bus.LED, 8'h02);
        check("ar_done_pulse", {7'd0, bus.done}, 8'h01);
        check("ar_still_running", {7'd0, bus.running}, 8'h01);
        step(1);
        check("ar_done_cleared", {7'd0, bus.done}, 8'h00);
        step(3);
        check("ar_01_again", bus.LED, 8'h01);
        load(4'd0, 4'd0);
`endif

        // 3: pause at 15 for 20 cycles, resume waits a full period
        load(4'd1, 4'd6);
        start();
        step(4);
        check("t3_15", bus.LED, 8'h15);
        start();
        check("t3_paused", {7'd0, bus.running}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("t3_hold", bus.LED, 8'h15);
        end
        start();
        check("t3_resumed", {7'd0, bus.running}, 8'h01);
        step(3);
        check("t3_resume_hold", bus.LED, 8'h15);
        step(1);
        check("t3_14", bus.LED, 8'h14);

        // 4: load on the tick cycle at 37 wins, no decrement
        load(4'd3, 4'd8);
        start();
        step(4);
        check("t4_37", bus.LED, 8'h37);
        step(3);
        load(4'd8, 4'd8);
        check("t4_load_wins", bus.LED, 8'h88);
        check("t4_idle", {7'd0, bus.running}, 8'h00);
        step(5);
        check("t4_idle_hold", bus.LED, 8'h88);
        // start together with tick: decrement, then PAUSE
        start();
        step(3);
        start();
        check("t4_tick_start_dec", bus.LED, 8'h87);
        check("t4_tick_start_pause", {7'd0, bus.running}, 8'h00);
        step(6);
        check("t4_pause_hold", bus.LED, 8'h87);

        // 5: clamping and zero preset
        load(4'hC, 4'hF);
        check("t5_clamp_cf", bus.LED, 8'h99);
        load(4'hA, 4'h5);
        check("t5_clamp_a5", bus.LED, 8'h95);
        load(4'd0, 4'd0);
        check("t5_zero_load", bus.LED, 8'h00);
        start();
        check("t5_zero_done", {7'd0, bus.done}, 8'h01);
        check("t5_zero_not_running", {7'd0, bus.running}, 8'h00);
        check("t5_zero_led", bus.LED, 8'h00);

        // 6: reset mid-RUN at 41
        load(4'd4, 4'd2);
        start();
        step(4);
        check("t6_41", bus.LED, 8'h41);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_led", bus.LED, 8'h00);
        check("t6_rst_running", {7'd0, bus.running}, 8'h00);
        check("t6_rst_done", {7'd0, bus.done}, 8'h00);
        load(4'd0, 4'd3);
        start();
        step(3);
        check("t6_after_rst_hold", bus.LED, 8'h03);
        step(1);
        check("t6_after_rst_02", bus.LED, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
